sccb_init_seq: RTL and testbench
================================

# sccb_init_seq

Sequences an Omnivision camera's power-up register configuration over SCCB. It walks an external register table of `{register, value}` entries and issues a 3-phase SCCB write for each one. It generates SIOC and a tri-stated SIOD at a programmable bit rate. It replaces the AXI IIC path for boot-time configuration and drives the same SIOC/SIOD pads through the top-level pad logic.

## Interface
Parameters:
- `CLK_DIV`, 250: clock cycles per quarter SIOC period (100 MHz / (4·250) = 100 kHz SIOC); must be ≥ 2.
- `DEV_ID`, 8'h42: SCCB write ID byte (bit 0 = 0).
- `ADDR_W`, 8: table address width.
- `DELAY_CYCLES`, 100000: clock cycles per delay unit (1 ms at 100 MHz).

Ports:
- `clk`, in, 1: system clock, the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to run the table from address 0. Ignored while `busy`.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse when the table completes.
- `rom_addr`, out, ADDR_W: table read address.
- `rom_data`, in, 16: `{reg[15:8], val[7:0]}`. Valid exactly one cycle after `rom_addr` changes.
- `sioc`, out, 1: SCCB clock, push-pull, active-high.
- `siod_o`, out, 1: SIOD drive value.
- `siod_oe`, out, 1: 1 drives `siod_o` onto SIOD; 0 floats SIOD.

## Operation
- Reset values: `busy`=0, `done`=0, `rom_addr`=0, `sioc`=1, `siod_o`=1, `siod_oe`=0, state IDLE, all counters 0.
- States: IDLE → FETCH → DECODE → {START → BYTE → STOP → GAP → FETCH | DELAY → FETCH | DONE → IDLE}.
- IDLE: on `start`=1, clear `rom_addr` and go to FETCH.
- FETCH: hold for one cycle so `rom_data` becomes valid.
- DECODE: latch `rom_data` and branch on it.
  - `16'hFFFF` → DONE.
  - `reg==8'hF0` → DELAY. Camera register 0xF0 is therefore not writable through this block.
  - Any other value → START.
- DELAY: wait `val·DELAY_CYCLES` cycles, then increment `rom_addr` and go to FETCH. `val=0` goes to FETCH on the next cycle.
- Quarter tick: a free-running counter of `CLK_DIV` cycles, restarted on entry to START, DELAY and GAP.
- START, 3 quarters:
  - Q0: `siod_oe`=1, `siod_o`=1, `sioc`=1.
  - Q1–Q2: `siod_o`=0, `sioc`=1.
- BYTE: 3 bytes in order `DEV_ID`, `reg`, `val`, each sent MSB first as 8 data bits plus a 9th don't-care bit, 4 quarters per bit.
  - Data bits: Q0–Q1 `sioc`=0, with `siod_o` updated at the start of Q0; Q2–Q3 `sioc`=1.
  - 9th bit: `siod_oe`=0 for all 4 quarters; SIOD is not sampled and there is no ACK check.
  - `siod_oe` returns to 1 at Q0 of the next byte or of STOP.
- STOP, 4 quarters:
  - Q0: `sioc`=0, `siod_o`=0.
  - Q1: `sioc`=1, `siod_o`=0.
  - Q2: `siod_o`=1.
  - Q3: `siod_oe`=0.
- GAP: 4 idle quarters with `sioc`=1 and `siod_oe`=0. Then increment `rom_addr` and go to FETCH.
- DONE: pulse `done`, drop `busy` in the same cycle, go to IDLE.
- Address wrap: after executing the entry at `rom_addr = 2^ADDR_W − 1`, go to DONE. The address never wraps to 0.
- `start` asserted while `busy`: ignored, and not queued.
- `rst_n` low mid-transaction: all outputs take their reset values immediately, without waiting for a clock edge. This releases SIOD and parks SIOC high. No STOP condition is generated.

## Timing
- `busy` rises on the cycle after the `start` edge; `rom_addr`=0 on that same cycle.
- Each write entry costs 2 + 119·CLK_DIV cycles: FETCH, DECODE, then 3+108+4+4 quarters.
- Each delay entry costs 2 + val·DELAY_CYCLES cycles.
- The end marker costs 2 cycles, plus 1 cycle for DONE.
- SIOC high and low phases are each exactly 2·CLK_DIV cycles.
- SIOD changes only while `sioc`=0, except for the start and stop edges.

## Test plan
- CLK_DIV=2, table `{16'h1280, 16'hFFFF}`, pulse `start`:
  - SIOD sampled on SIOC rising edges reads 0x42, 0x12, 0x80.
  - `siod_oe`=0 throughout each 9th bit.
  - `done` pulses once, 2+238+2+1 cycles after `busy` rises.
- CLK_DIV=2, DELAY_CYCLES=10, table `{16'hF003, 16'h1100, 16'hFFFF}`: SIOC stays high with SIOD floating for exactly 30 cycles before the 0x42 start condition.
- Table `{16'hFFFF}`: no SIOC toggle; `done` pulses 3 cycles after `busy` rises.
- ADDR_W=2, no end marker, 4 write entries: 4 transactions at addresses 0–3, then `done`; `rom_addr` never returns to 0 while `busy`.
- Pulse `start` again mid-transaction: no effect on the SIOC/SIOD waveform or on `rom_addr`.
- Assert `rst_n`=0 during the 2nd byte: `sioc`=1 and `siod_oe`=0 with no clock edge. After release, `start` reruns the table from address 0 and produces a correct 0x42 sequence.

Source files
------------

// File: rtl/sccb_init_seq.sv
`timescale 1ns/1ps
// sccb_init_seq: walks a {reg,val} table, issuing one SCCB 3-phase write or delay per entry.
module sccb_init_seq #(
  parameter int unsigned CLK_DIV      = 250,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DELAY_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0]     Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     D_LAST    = DW'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BYTE, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [QW-1:0]     qcnt, qcnt_nxt;
  logic [1:0]        quarter, quarter_nxt;
  logic [3:0]        bit_idx, bit_idx_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [DW-1:0]     dly_cyc, dly_cyc_nxt;
  logic [7:0]        dly_unit, dly_unit_nxt;
  logic [7:0]        reg_q, reg_nxt;
  logic [7:0]        val_q, val_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              busy_nxt, done_nxt, sioc_nxt, siod_o_nxt, siod_oe_nxt;
  logic              entry_done;
  logic [7:0]        tx_byte;
  logic              tick;

  // Last clock of the current quarter SIOC period.
  assign tick = (qcnt == Q_LAST);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      dly_cyc  <= '0;
      dly_unit <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sioc     <= 1'b1;
      siod_o   <= 1'b1;
      siod_oe  <= 1'b0;
    end else begin
      state    <= state_nxt;
      qcnt     <= qcnt_nxt;
      quarter  <= quarter_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      dly_cyc  <= dly_cyc_nxt;
      dly_unit <= dly_unit_nxt;
      reg_q    <= reg_nxt;
      val_q    <= val_nxt;
      rom_addr <= addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      sioc     <= sioc_nxt;
      siod_o   <= siod_o_nxt;
      siod_oe  <= siod_oe_nxt;
    end
  end

  // Next-state sequencing, then output decode from the next-cycle position.
  always_comb begin
    state_nxt    = state;
    qcnt_nxt     = tick ? '0 : qcnt + QW'(1);
    quarter_nxt  = quarter;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    dly_cyc_nxt  = dly_cyc;
    dly_unit_nxt = dly_unit;
    reg_nxt      = reg_q;
    val_nxt      = val_q;
    addr_nxt     = rom_addr;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    sioc_nxt     = 1'b1;
    siod_o_nxt   = 1'b1;
    siod_oe_nxt  = 1'b0;
    entry_done   = 1'b0;
    tx_byte      = DEV_ID;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        reg_nxt      = rom_data[15:8];
        val_nxt      = rom_data[7:0];
        qcnt_nxt     = '0;
        quarter_nxt  = '0;
        bit_idx_nxt  = '0;
        byte_idx_nxt = '0;
        dly_cyc_nxt  = '0;
        dly_unit_nxt = '0;
        if (rom_data == 16'hFFFF)       state_nxt = S_DONE;
        else if (rom_data[15:8] == 8'hF0) state_nxt = S_DELAY;
        else                            state_nxt = S_START;
      end
      S_START: begin
        if (tick) begin
          quarter_nxt = quarter + 2'd1;
          if (quarter == 2'd2) begin
            state_nxt   = S_BYTE;
            quarter_nxt = '0;
          end
        end
      end
      S_BYTE: begin
        if (tick) begin
          quarter_nxt = quarter + 2'd1;
          if (quarter == 2'd3) begin
            if (bit_idx == 4'd8) begin
              bit_idx_nxt = '0;
              if (byte_idx == 2'd2) state_nxt = S_STOP;
              else                  byte_idx_nxt = byte_idx + 2'd1;
            end else begin
              bit_idx_nxt = bit_idx + 4'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          quarter_nxt = quarter + 2'd1;
          if (quarter == 2'd3) state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          quarter_nxt = quarter + 2'd1;
          if (quarter == 2'd3) entry_done = 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_cyc == D_LAST) begin
          dly_cyc_nxt  = '0;
          dly_unit_nxt = dly_unit + 8'd1;
        end else begin
          dly_cyc_nxt = dly_cyc + DW'(1);
        end
        if ((val_q == 8'd0) || ((dly_unit == val_q - 8'd1) && (dly_cyc == D_LAST)))
          entry_done = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Advance to the next entry; the last table address ends the run instead of wrapping.
    if (entry_done) begin
      if (rom_addr == ADDR_LAST) begin
        state_nxt = S_DONE;
      end else begin
        addr_nxt  = rom_addr + ADDR_W'(1);
        state_nxt = S_FETCH;
      end
    end

    case (byte_idx_nxt)
      2'd0:    tx_byte = DEV_ID;
      2'd1:    tx_byte = reg_nxt;
      default: tx_byte = val_nxt;
    endcase

    case (state_nxt)
      S_START: begin
        siod_oe_nxt = 1'b1;
        siod_o_nxt  = (quarter_nxt == 2'd0);
      end
      S_BYTE: begin
        sioc_nxt = quarter_nxt[1];
        if (bit_idx_nxt == 4'd8) begin
          siod_oe_nxt = 1'b0;
          siod_o_nxt  = 1'b0;
        end else begin
          siod_oe_nxt = 1'b1;
          siod_o_nxt  = tx_byte[3'(4'd7 - bit_idx_nxt)];
        end
      end
      S_STOP: begin
        sioc_nxt    = (quarter_nxt != 2'd0);
        siod_o_nxt  = quarter_nxt[1];
        siod_oe_nxt = (quarter_nxt != 2'd3);
      end
      default: begin
        sioc_nxt    = 1'b1;
        siod_o_nxt  = 1'b1;
        siod_oe_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
`timescale 1ns/1ps
// tb_sccb_init_seq: table vectors, hand sequences and random tables against a transaction-level model.
module tb_sccb_init_seq;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DLY     = 10;
  localparam int unsigned WR_COST = 2 + 119 * CLK_DIV;

  typedef logic [3:0][15:0] tbl_t;
  typedef struct {
    string name;
    tbl_t  tbl;
    int    lat;
  } vec_t;

  logic       clk, rst_n, start;
  logic       busy, done, sioc, siod_o, siod_oe;
  logic [1:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] rom [4];

  int n_checks = 0;
  int n_fail   = 0;

  sccb_init_seq #(
    .CLK_DIV(CLK_DIV), .DEV_ID(8'h42), .ADDR_W(2), .DELAY_CYCLES(DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .sioc(sioc),
    .siod_o(siod_o), .siod_oe(siod_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous table ROM: data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Bus monitor: decodes SCCB frames from the pins.
  int          cyc = 0, bitpos = 27, rises = 0, bus_bad = 0, addr_back0 = 0;
  int          done_pulses = 0, busy_rise_cyc = 0;
  logic [7:0]  shreg;
  logic        p_sioc = 1'b1, p_siod = 1'b1, p_oe = 1'b0, p_busy = 1'b0, p_done = 1'b0;
  logic [1:0]  p_addr = 2'd0;
  logic [7:0]  rx [$];
  int          start_cyc [$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitpos = 27;
      p_sioc = 1'b1; p_siod = 1'b1; p_oe = 1'b0; p_busy = 1'b0; p_done = 1'b0; p_addr = 2'd0;
    end else begin
      if (!p_busy && busy) busy_rise_cyc = cyc;
      if (done && !p_done) done_pulses++;
      if (busy && p_busy && p_addr != 2'd0 && rom_addr == 2'd0) addr_back0++;
      if (!p_oe && siod_oe && sioc) start_cyc.push_back(cyc);
      if (p_sioc && sioc && p_oe && siod_oe && p_siod && !siod_o) begin
        bitpos = 0;
        shreg  = 8'h00;
      end else if (!p_sioc && sioc) begin
        rises++;
        if (bitpos < 27) begin
          if (bitpos % 9 < 8) begin
            if (!siod_oe) bus_bad++;
            shreg = {shreg[6:0], siod_o};
          end else begin
            if (siod_oe) bus_bad++;
            rx.push_back(shreg);
          end
          bitpos++;
        end
      end
      p_sioc = sioc; p_siod = siod_o; p_oe = siod_oe; p_busy = busy; p_done = done; p_addr = rom_addr;
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected bytes, start offsets and done latency from the table rules.
  logic [7:0] exp_bytes [$];
  int         exp_off [$];

  task automatic model(input tbl_t t, output int lat, output int nwr);
    exp_bytes.delete();
    exp_off.delete();
    lat = 0;
    nwr = 0;
    for (int a = 0; a < 4; a++) begin
      if (t[a] == 16'hFFFF) begin
        lat += 2;
        break;
      end else if (t[a][15:8] == 8'hF0) begin
        lat += 2 + ((t[a][7:0] == 8'd0) ? 1 : int'(t[a][7:0]) * DLY);
      end else begin
        exp_off.push_back(lat + 2);
        exp_bytes.push_back(8'h42);
        exp_bytes.push_back(t[a][15:8]);
        exp_bytes.push_back(t[a][7:0]);
        lat += WR_COST;
        nwr++;
      end
    end
    lat += 1;
  endtask

  task automatic run_case(input string name, input tbl_t t, input int exp_lat, input int mid_start);
    int lat_m, nwr, n, b_base, s_base, r_base, bb_base, a0_base, d_base;
    model(t, lat_m, nwr);
    if (exp_lat < 0) exp_lat = lat_m;
    for (int a = 0; a < 4; a++) rom[a] = t[a];
    b_base = rx.size(); s_base = start_cyc.size(); r_base = rises;
    bb_base = bus_bad; a0_base = addr_back0; d_base = done_pulses;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({name, " busy_rise"}, 32'(busy), 32'd1);
    chk({name, " addr_start"}, 32'(rom_addr), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
      if (mid_start > 0 && n == mid_start) start = 1'b1;
      if (mid_start > 0 && n == mid_start + 1) begin
        start = 1'b0;
        chk({name, " addr_after_restart"}, 32'(rom_addr), 32'd0);
        chk({name, " busy_after_restart"}, 32'(busy), 32'd1);
      end
    end
    chk({name, " done_latency"}, 32'(n), 32'(exp_lat));
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, " done_width"}, 32'(done), 32'd0);
    chk({name, " done_pulses"}, 32'(done_pulses - d_base), 32'd1);
    chk({name, " byte_count"}, 32'(rx.size() - b_base), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      if (b_base + i < rx.size())
        chk($sformatf("%s byte%0d", name, i), 32'(rx[b_base + i]), 32'(exp_bytes[i]));
    chk({name, " start_count"}, 32'(start_cyc.size() - s_base), 32'(exp_off.size()));
    for (int i = 0; i < exp_off.size(); i++)
      if (s_base + i < start_cyc.size())
        chk($sformatf("%s start_off%0d", name, i),
            32'(start_cyc[s_base + i] - busy_rise_cyc), 32'(exp_off[i]));
    chk({name, " sioc_rises"}, 32'(rises - r_base), 32'(28 * nwr));
    chk({name, " oe_pattern"}, 32'(bus_bad - bb_base), 32'd0);
    chk({name, " addr_no_wrap"}, 32'(addr_back0 - a0_base), 32'd0);
  endtask

  function automatic tbl_t mk(input logic [15:0] e0, e1, e2, e3);
    tbl_t t;
    t[0] = e0; t[1] = e1; t[2] = e2; t[3] = e3;
    return t;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int n, b_base;
    tbl_t t;

    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 4; a++) rom[a] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    chk("reset sioc", 32'(sioc), 32'd1);
    chk("reset siod_o", 32'(siod_o), 32'd1);
    chk("reset siod_oe", 32'(siod_oe), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{"one_write",   mk(16'h1280, 16'hFFFF, 16'h0000, 16'h0000), 243};
    vecs[1] = '{"marker_only", mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000), 3};
    vecs[2] = '{"delay_write", mk(16'hF003, 16'h1100, 16'hFFFF, 16'h0000), 275};
    vecs[3] = '{"no_marker",   mk(16'h1280, 16'h3456, 16'h789A, 16'hBCDE), 961};
    vecs[4] = '{"zero_delay",  mk(16'hF000, 16'hAB01, 16'hFFFF, 16'h0000), 246};
    vecs[5] = '{"two_delays",  mk(16'hF001, 16'hF002, 16'hFFFF, 16'h0000), 37};
    vecs[6] = '{"marker_last", mk(16'h0C5A, 16'hF001, 16'h9900, 16'hFFFF), 495};
    for (int v = 0; v < 7; v++) run_case(vecs[v].name, vecs[v].tbl, vecs[v].lat, 0);

    // start pulsed again while the first write is on the bus.
    run_case("mid_start", mk(16'h1280, 16'hFFFF, 16'h0000, 16'h0000), 243, 50);

    // Reset asserted during the second byte, then a clean rerun.
    t = mk(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    for (int a = 0; a < 4; a++) rom[a] = t[a];
    b_base = rx.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (rx.size() < b_base + 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst first_byte_seen", 32'(rx.size() - b_base), 32'd1);
    if (rx.size() > b_base) chk("rst first_byte", 32'(rx[b_base]), 32'h42);
    repeat (6) @(negedge clk);
    chk("rst pre sioc_low", 32'(sioc), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async sioc", 32'(sioc), 32'd1);
    chk("rst async siod_oe", 32'(siod_oe), 32'd0);
    chk("rst async siod_o", 32'(siod_o), 32'd1);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case("after_reset", t, 243, 0);

    // Random tables against the model.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 4; a++) begin
        int k;
        logic [7:0] rg;
        k = $urandom_range(0, 9);
        if (k == 0) begin
          t[a] = 16'hFFFF;
        end else if (k <= 2) begin
          t[a] = {8'hF0, 8'($urandom_range(0, 3))};
        end else begin
          rg = 8'($urandom);
          if (rg == 8'hF0) rg = 8'hF1;
          t[a] = {rg, 8'($urandom)};
        end
      end
      run_case($sformatf("rand%0d", r), t, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
